// File: rtl/usb_phase_select.sv
// USB2 receive phase controller: histograms data-edge positions across five
// oversampling phases and samples the recovered bit away from the dominant edge.
//
// state   | meaning
// IDLE    | disabled; counters clear, phase held
// ACQUIRE | first window after enable; phase taken unconditionally
// TRACK   | data emitted; phase moves only with MARGIN hysteresis
module usb_phase_select #(
  parameter int WINDOW       = 16,
  parameter int CNT_W        = 8,
  parameter int MARGIN       = 2,
  parameter int LOCK_WINDOWS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] samples,
  input  logic       sample_valid,
  output logic [2:0] phase_sel,
  output logic       data_out,
  output logic       data_valid,
  output logic       locked
);

  localparam int LK_W = (LOCK_WINDOWS > 1) ? $clog2(LOCK_WINDOWS + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];
  logic [CNT_W-1:0] cnt_inc [5];
  logic [CNT_W-1:0] win_q, win_d;
  logic [LK_W-1:0]  lock_q, lock_d;
  logic             prev_s4_q, prev_s4_d;
  logic             first_q, first_d;
  logic [2:0]       phase_q, phase_d;
  logic             data_q, data_d;
  logic             dv_q, dv_d;
  logic             locked_q, locked_d;

  logic [4:0]       edges;
  logic [2:0]       best_idx;
  logic [CNT_W-1:0] best_cnt;
  logic [2:0]       cand;
  logic [2:0]       cur_e;
  logic [CNT_W-1:0] cur_cnt;
  logic             win_close;
  logic             beats_margin;

  function automatic logic [2:0] add_mod5(input logic [2:0] a, input logic [2:0] k);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, k};
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  // Edge i sits between phase i and i+1; edge 4 wraps into the next bit period.
  always_comb begin
    edges[3:0] = samples[3:0] ^ samples[4:1];
    edges[4]   = (prev_s4_q ^ samples[0]) & ~first_q;
    for (int i = 0; i < 5; i++) begin
      cnt_inc[i] = (cnt_q[i] == {CNT_W{1'b1}}) ? cnt_q[i] : cnt_q[i] + CNT_W'(edges[i]);
    end
  end

  always_comb begin
    best_idx = 3'd0;
    best_cnt = cnt_inc[0];
    for (int i = 1; i < 5; i++) begin
      if (cnt_inc[i] > best_cnt) begin
        best_cnt = cnt_inc[i];
        best_idx = 3'(i);
      end
    end
    cand         = add_mod5(best_idx, 3'd3);
    cur_e        = add_mod5(phase_q, 3'd2);
    cur_cnt      = cnt_inc[cur_e];
    beats_margin = {1'b0, best_cnt} >= ({1'b0, cur_cnt} + (CNT_W+1)'(MARGIN));
    win_close    = (win_q == CNT_W'(WINDOW - 1));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    lock_d    = lock_q;
    prev_s4_d = prev_s4_q;
    first_d   = first_q;
    phase_d   = phase_q;
    data_d    = data_q;
    dv_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ACQUIRE;
          first_d = 1'b1;
        end
      end
      ACQUIRE, TRACK: begin
        if (!enable) begin
          state_d = IDLE;
          for (int i = 0; i < 5; i++) cnt_d[i] = '0;
          win_d  = '0;
          lock_d = '0;
        end else if (sample_valid) begin
          prev_s4_d = samples[4];
          first_d   = 1'b0;
          if (state_q == TRACK) begin
            data_d = samples[phase_q];
            dv_d   = 1'b1;
          end
          if (win_close) begin
            win_d = '0;
            for (int i = 0; i < 5; i++) cnt_d[i] = '0;
            if (state_q == ACQUIRE) begin
              state_d = TRACK;
              lock_d  = '0;
              if (best_cnt != '0) phase_d = cand;
            end else if (best_cnt != '0 && cand != phase_q && beats_margin) begin
              phase_d = cand;
              lock_d  = '0;
            end else if (lock_q != LK_W'(LOCK_WINDOWS)) begin
              lock_d = lock_q + LK_W'(1);
            end
          end else begin
            win_d = win_q + CNT_W'(1);
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    locked_d = (lock_d == LK_W'(LOCK_WINDOWS));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      win_q     <= '0;
      lock_q    <= '0;
      prev_s4_q <= 1'b0;
      first_q   <= 1'b0;
      phase_q   <= 3'd0;
      data_q    <= 1'b0;
      dv_q      <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      lock_q    <= lock_d;
      prev_s4_q <= prev_s4_d;
      first_q   <= first_d;
      phase_q   <= phase_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      locked_q  <= locked_d;
    end
  end

  assign phase_sel  = phase_q;
  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign locked     = locked_q;

endmodule
